vga_fill_sched: RTL and testbench
=================================

VGA_FILL_SCHED -- requirements
Module: vga_fill_sched

Interface
REQ-001 Parameter XMAX, default 159, last valid frame-buffer column.
REQ-002 Parameter YMAX, default 119, last valid frame-buffer row.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  fill command pending on port 0 / port 1.
REQ-006 req0_ready, req1_ready  output  1 each  command accepted when valid and ready are both high in the same cycle.
REQ-007 req0_x0, req0_x1, req1_x0, req1_x1  input  8 each  rectangle corner columns.
REQ-008 req0_y0, req0_y1, req1_y0, req1_y1  input  7 each  rectangle corner rows.
REQ-009 req0_color, req1_color  input  9 each  fill color, 3 bits per channel.
REQ-010 x  output  8  frame-buffer write column (registered).
REQ-011 y  output  7  frame-buffer write row (registered).
REQ-012 color  output  9  frame-buffer write color (registered).
REQ-013 writeEn  output  1  write strobe; one pixel per high cycle.
REQ-014 busy  output  1  high in FILL and DONE.
REQ-015 grant  output  1  port index of the command being executed or last executed.
REQ-016 done  output  1  single-cycle pulse after a command completes.

Function
REQ-017 The FSM SHALL have states IDLE, FILL, DONE.
REQ-018 In IDLE with one port valid, that port SHALL be the winner; with both valid, the port other than last_grant SHALL win.
REQ-019 reqN_ready SHALL be high only in IDLE, only for the winning port, and combinationally on that port's valid; the losing port's ready SHALL be 0.
REQ-020 Both readies SHALL be 0 in FILL and DONE; pending commands are held by the requester, not queued.
REQ-021 On handshake, the block SHALL latch the command, set grant and last_grant to the winning port, and normalise corners: xa=min(x0,x1), xb=min(max(x0,x1),XMAX); ya, yb likewise against YMAX.
REQ-022 If min(x0,x1)>XMAX or min(y0,y1)>YMAX, the rectangle SHALL be empty: go IDLE->DONE with no writes.
REQ-023 Otherwise IDLE->FILL; the first writeEn SHALL occur in the cycle after the handshake, with x=xa, y=ya and the latched color.
REQ-024 In FILL, writeEn SHALL be 1 every cycle, in raster order: x increments; when x=xb, x reloads xa and y increments.
REQ-025 The write at (xb,yb) SHALL be the last write; the next cycle SHALL be DONE.
REQ-026 Pixel count SHALL be exactly (xb-xa+1)*(yb-ya+1); no skipped or duplicated pixels.
REQ-027 DONE SHALL last one cycle with done=1 and writeEn=0, then return to IDLE.
REQ-028 x, y and color SHALL hold their last values whenever writeEn=0.
REQ-029 All corner comparisons SHALL be unsigned at the stated port widths; x/y arithmetic SHALL never wrap past XMAX/YMAX.

Reset
REQ-030 When reset=1: state=IDLE; x=0, y=0, color=0; writeEn=0, busy=0, done=0, grant=0; last_grant=1, so port 0 wins the first tie.
REQ-031 Reset asserted mid-FILL SHALL abort the command: writeEn=0 from the next cycle, with no done pulse.
REQ-032 Reset SHALL take priority over any handshake in the same cycle.

Verification
REQ-033 Port0 (5,7)-(5,7), color 0x1FF, handshake at cycle N -> exactly one write at N+1 (x=5, y=7, color=0x1FF); done at N+2; ready again at N+3.
REQ-034 Port1 (3,2)-(1,1) -> 6 writes at (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); grant=1.
REQ-035 Clipping: (158,118)-(200,127) -> 4 writes ending at (159,119); (160,0)-(170,5) -> zero writes, done at N+1.
REQ-036 After reset, both ports valid continuously -> port0 served first, port1 next, then port0, alternating; the loser's ready stays 0 while the other port is served.
REQ-037 Full screen (0,0)-(159,119) -> 19200 consecutive writeEn cycles, last at (159,119); busy high for 19201 cycles.
REQ-038 Reset pulse at the 10th write of a 10x10 fill -> writeEn=0 next cycle, state IDLE, no done, all outputs at reset values.

Source files
------------

// File: rtl/vga_fill_sched.sv
// Two-port rectangle-fill scheduler: arbitrates fill commands and rasters pixels to a frame buffer.
// First write one cycle after handshake, one pixel per cycle; requesters hold commands while busy (ready low).
module vga_fill_sched #(
    parameter int XMAX = 159,
    parameter int YMAX = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_x0,
    input  logic [7:0] req0_x1,
    input  logic [6:0] req0_y0,
    input  logic [6:0] req0_y1,
    input  logic [8:0] req0_color,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_x0,
    input  logic [7:0] req1_x1,
    input  logic [6:0] req1_y0,
    input  logic [6:0] req1_y1,
    input  logic [8:0] req1_color,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] color,
    output logic       writeEn,
    output logic       busy,
    output logic       grant,
    output logic       done
);

    localparam logic [7:0] XLIM = 8'(XMAX);
    localparam logic [6:0] YLIM = 7'(YMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic       last_grant;
    logic       win;
    logic       any_valid;
    logic       hs;

    logic [7:0] sel_x0, sel_x1;
    logic [6:0] sel_y0, sel_y1;
    logic [8:0] sel_color;

    logic [7:0] xa_n, xhi_n, xb_n;
    logic [6:0] ya_n, yhi_n, yb_n;
    logic       empty_n;

    logic [7:0] xa, xb;
    logic [6:0] yb;
    logic       x_last, last_px;

    // Round-robin on ties: the port that did not win last time goes first.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = req1_valid;
        end
        hs = (state == IDLE) && any_valid && !reset;
    end

    always_comb begin
        sel_x0    = win ? req1_x0    : req0_x0;
        sel_x1    = win ? req1_x1    : req0_x1;
        sel_y0    = win ? req1_y0    : req0_y0;
        sel_y1    = win ? req1_y1    : req0_y1;
        sel_color = win ? req1_color : req0_color;
    end

    // Corner normalisation: order the corners, clip the far edge to the screen.
    always_comb begin
        xa_n    = (sel_x0 < sel_x1) ? sel_x0 : sel_x1;
        xhi_n   = (sel_x0 < sel_x1) ? sel_x1 : sel_x0;
        xb_n    = (xhi_n > XLIM) ? XLIM : xhi_n;
        ya_n    = (sel_y0 < sel_y1) ? sel_y0 : sel_y1;
        yhi_n   = (sel_y0 < sel_y1) ? sel_y1 : sel_y0;
        yb_n    = (yhi_n > YLIM) ? YLIM : yhi_n;
        empty_n = (xa_n > XLIM) || (ya_n > YLIM);
    end

    always_comb begin
        x_last  = (x == xb);
        last_px = x_last && (y == yb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = empty_n ? DONE : FILL;
                end
            end
            FILL: begin
                if (last_px) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && !reset && req0_valid && !win;
        req1_ready = (state == IDLE) && !reset && req1_valid && win;
        writeEn    = (state == FILL);
        busy       = (state == FILL) || (state == DONE);
        done       = (state == DONE);
    end

    // Pixel position only moves while filling, so x/y/color hold whenever writeEn is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            color      <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            xa         <= '0;
            xb         <= '0;
            yb         <= '0;
        end else if (hs) begin
            grant      <= win;
            last_grant <= win;
            xa         <= xa_n;
            xb         <= xb_n;
            yb         <= yb_n;
            if (!empty_n) begin
                x     <= xa_n;
                y     <= ya_n;
                color <= sel_color;
            end
        end else if (state == FILL && !last_px) begin
            if (x_last) begin
                x <= xa;
                y <= y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fill_sched.sv
// Directed bench for vga_fill_sched: expected pixels/done pulses queued at issue, checked by a negedge monitor.
module tb_vga_fill_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0v, r1v;
    logic       req0_ready, req1_ready;
    logic [7:0] r0x0, r0x1, r1x0, r1x1;
    logic [6:0] r0y0, r0y1, r1y0, r1y1;
    logic [8:0] r0c, r1c;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] color;
    logic       writeEn, busy, grant, done;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [23:0] exp_px[$];
    logic        exp_dn[$];

    always #5 clk = ~clk;

    vga_fill_sched dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_ready(req0_ready),
        .req0_x0(r0x0), .req0_x1(r0x1), .req0_y0(r0y0), .req0_y1(r0y1), .req0_color(r0c),
        .req1_valid(r1v), .req1_ready(req1_ready),
        .req1_x0(r1x0), .req1_x1(r1x1), .req1_y0(r1y0), .req1_y1(r1y1), .req1_color(r1c),
        .x(x), .y(y), .color(color), .writeEn(writeEn), .busy(busy), .grant(grant), .done(done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_px(input int px, input int py, input int pc);
        exp_px.push_back({8'(px), 7'(py), 9'(pc)});
    endtask

    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            wr_cnt++;
            chk("pending_write", int'(exp_px.size() > 0), 1);
            if (exp_px.size() > 0) chk("write_pixel", int'({x, y, color}), int'(exp_px.pop_front()));
        end
        if (done === 1'b1) begin
            chk("pending_done", int'(exp_dn.size() > 0), 1);
            if (exp_dn.size() > 0) chk("done_grant", int'(grant), int'(exp_dn.pop_front()));
        end
    end

    task automatic set_req(input int p, input int x0, input int y0, input int x1, input int y1, input int c);
        if (p == 0) begin
            r0x0 = 8'(x0); r0y0 = 7'(y0); r0x1 = 8'(x1); r0y1 = 7'(y1); r0c = 9'(c); r0v = 1'b1;
        end else begin
            r1x0 = 8'(x0); r1y0 = 7'(y0); r1x1 = 8'(x1); r1y1 = 7'(y1); r1c = 9'(c); r1v = 1'b1;
        end
    endtask

    // Returns 1ns after the handshake edge.
    task automatic send(input int p, input int x0, input int y0, input int x1, input int y1, input int c);
        int n;
        logic rdy;
        @(posedge clk); #1;
        set_req(p, x0, y0, x1, y1, c);
        n = 0;
        do begin
            @(negedge clk);
            rdy = (p == 0) ? req0_ready : req1_ready;
            n++;
        end while (!rdy && n < 100);
        chk("ready_seen", int'(rdy), 1);
        @(posedge clk); #1;
        if (p == 0) r0v = 1'b0; else r1v = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, viol, bc, w, n;
        reset = 1'b1;
        r0v = 1'b0; r1v = 1'b0;
        set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
        r0v = 1'b0; r1v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_writeEn", int'(writeEn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_grant", int'(grant), 0);

        // A request presented during reset must not be taken.
        set_req(0, 5, 5, 5, 5, 9'h0AA);
        #1 chk("rst_ready0", int'(req0_ready), 0);
        @(negedge clk);
        chk("rst_no_hs", int'(busy), 0);
        r0v = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Single pixel: write at N+1, done at N+2, ready at N+3.
        push_px(5, 7, 9'h1FF); exp_dn.push_back(1'b0);
        send(0, 5, 7, 5, 7, 9'h1FF);
        @(negedge clk);
        chk("p1_we", int'(writeEn), 1);
        @(negedge clk);
        chk("p1_done", int'(done), 1);
        chk("p1_we_done", int'(writeEn), 0);
        push_px(5, 7, 9'h1FF); exp_dn.push_back(1'b0);
        set_req(0, 5, 7, 5, 7, 9'h1FF);
        #1 chk("p1_ready_in_done", int'(req0_ready), 0);
        @(negedge clk);
        chk("p1_ready_n3", int'(req0_ready), 1);
        @(posedge clk); #1 r0v = 1'b0;
        wait_idle(20);

        // Swapped corners on port 1.
        push_px(1, 1, 9'h0F0); push_px(2, 1, 9'h0F0); push_px(3, 1, 9'h0F0);
        push_px(1, 2, 9'h0F0); push_px(2, 2, 9'h0F0); push_px(3, 2, 9'h0F0);
        exp_dn.push_back(1'b1);
        send(1, 3, 2, 1, 1, 9'h0F0);
        wait_idle(20);
        chk("p2_grant", int'(grant), 1);

        // Clipped to the bottom-right corner.
        push_px(158, 118, 9'h155); push_px(159, 118, 9'h155);
        push_px(158, 119, 9'h155); push_px(159, 119, 9'h155);
        exp_dn.push_back(1'b0);
        w = wr_cnt;
        send(0, 158, 118, 200, 127, 9'h155);
        wait_idle(20);
        chk("clip_count", wr_cnt - w, 4);
        chk("clip_x", int'(x), 159);
        chk("clip_y", int'(y), 119);

        // Fully off-screen: no writes, done right after handshake.
        exp_dn.push_back(1'b1);
        w = wr_cnt;
        send(1, 160, 0, 170, 5, 9'h1AB);
        @(negedge clk);
        chk("empty_done", int'(done), 1);
        chk("empty_we", int'(writeEn), 0);
        wait_idle(20);
        chk("empty_count", wr_cnt - w, 0);
        chk("empty_hold_x", int'(x), 159);

        // Alternation with both ports held valid, starting from reset.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_px(1, 1, 9'h011); exp_dn.push_back(1'b0);
            push_px(2, 2, 9'h022); exp_dn.push_back(1'b1);
        end
        set_req(0, 1, 1, 1, 1, 9'h011);
        set_req(1, 2, 2, 2, 2, 9'h022);
        k = 0; viol = 0; n = 0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy && (req0_ready || req1_ready)) viol++;
            if (req0_ready || req1_ready) begin
                chk("arb_single", int'(req0_ready && req1_ready), 0);
                chk("arb_order", int'(req1_ready), k % 2);
                k++;
            end
        end
        chk("arb_grants", k, 4);
        @(posedge clk); #1 r0v = 1'b0; r1v = 1'b0;
        wait_idle(20);
        chk("arb_busy_ready", viol, 0);

        // Full screen.
        for (int yy = 0; yy <= 119; yy++)
            for (int xx = 0; xx <= 159; xx++)
                push_px(xx, yy, 9'h1C7);
        exp_dn.push_back(1'b0);
        send(0, 0, 0, 159, 119, 9'h1C7);
        bc = 0; w = 0; n = 0;
        @(negedge clk);
        while (busy && n < 20010) begin
            bc++;
            if (writeEn) w++;
            @(negedge clk);
            n++;
        end
        chk("full_busy_cycles", bc, 19201);
        chk("full_writes", w, 19200);
        chk("full_last_x", int'(x), 159);
        chk("full_last_y", int'(y), 119);

        // Reset during the 10th write of a 10x10 fill.
        for (int xx = 0; xx < 10; xx++) push_px(xx, 0, 9'h0AA);
        send(0, 0, 0, 9, 9, 9'h0AA);
        w = 0; n = 0;
        while (w < 10 && n < 50) begin
            @(negedge clk);
            n++;
            if (writeEn) w++;
        end
        chk("abort_reached", w, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_we", int'(writeEn), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x", int'(x), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_color", int'(color), 0);
        chk("abort_grant", int'(grant), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_idle_we", int'(writeEn), 0);

        chk("px_queue_drained", exp_px.size(), 0);
        chk("done_queue_drained", exp_dn.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
